// File: rtl/mem_stage_pkg.sv
// Shared types for the EX/MEM/WB boundary: load-op encodings and stage payload layouts.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_stage_pkg;

    localparam int LOAD_OP_W  = 3;
    localparam int ADDR_LSB_W = 2;

    // Encodings 5..7 are not listed; consumers treat them as a full-word load.
    typedef enum logic [LOAD_OP_W-1:0] {
        LD_W  = 3'd0,
        LD_B  = 3'd1,
        LD_H  = 3'd2,
        LD_BU = 3'd3,
        LD_HU = 3'd4
    } load_op_e;

    // EX -> MEM payload, 74 bits; the first field is the MSB.
    typedef struct packed {
        logic [31:0]          pc;           // [73:42]
        logic                 gr_we;        // [41]
        logic [4:0]           dest;         // [40:36]
        logic [31:0]          alu_result;   // [35:4]
        logic                 res_from_mem; // [3]
        logic [LOAD_OP_W-1:0] load_op;      // [2:0]
    } ex_mem_t;

    // MEM -> WB payload, 70 bits.
    typedef struct packed {
        logic [31:0] pc;           // [69:38]
        logic        gr_we;        // [37]
        logic [4:0]  dest;         // [36:32]
        logic [31:0] final_result; // [31:0]
    } mem_wb_t;

    // MEM -> ID bypass bundle, 38 bits.
    typedef struct packed {
        logic        fwd_we;       // [37]
        logic [4:0]  dest;         // [36:32]
        logic [31:0] final_result; // [31:0]
    } mem_fwd_t;

endpackage

// File: rtl/mem_stage_if.sv
// Bundle of all MEM-stage handshake and data signals (EX side, SRAM read data, WB side, bypass).
// Latency: n/a (wiring only).
// Backpressure: MEM_allow_in towards EX, WB_allow_in from WB.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic        WB_allow_in;
    logic        EX_to_MEM_valid;
    ex_mem_t     EX_MEM_reg;
    logic [31:0] data_sram_rdata;
    logic        MEM_allow_in;
    logic        MEM_to_WB_valid;
    mem_wb_t     MEM_WB_reg;
    mem_fwd_t    MEM_fwd;

    // The MEM stage itself.
    modport slave (
        input  WB_allow_in, EX_to_MEM_valid, EX_MEM_reg, data_sram_rdata,
        output MEM_allow_in, MEM_to_WB_valid, MEM_WB_reg, MEM_fwd
    );

    // The surrounding pipeline (EX, SRAM, WB, ID).
    modport master (
        output WB_allow_in, EX_to_MEM_valid, EX_MEM_reg, data_sram_rdata,
        input  MEM_allow_in, MEM_to_WB_valid, MEM_WB_reg, MEM_fwd
    );

endinterface

// File: rtl/mem_stage_load_align.sv
// Sub-word load alignment: picks byte/half by address offset and sign/zero-extends.
// Latency: combinational.
// Backpressure: none.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0]           i_word,
    input  logic [ADDR_LSB_W-1:0] i_off,
    input  logic [LOAD_OP_W-1:0]  i_load_op,
    output logic [31:0]           o_value
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane select; the half ignores off[0], so misaligned halves are not trapped.
    always_comb begin
        w_byte = i_word[{i_off, 3'b000} +: 8];
        w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
    end

    // Extension by load type; unknown encodings fall back to the whole word.
    always_comb begin
        o_value = i_word;
        case (i_load_op)
            LD_B:    o_value = {{24{w_byte[7]}}, w_byte};
            LD_H:    o_value = {{16{w_half[15]}}, w_half};
            LD_BU:   o_value = {24'd0, w_byte};
            LD_HU:   o_value = {16'd0, w_half};
            default: o_value = i_word;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches EX payload, consumes SRAM read data, aligns loads.
// Latency: 1 cycle EX->WB; result is combinational from stage registers and SRAM data.
// Backpressure: MEM_allow_in drops while holding a valid instruction WB will not take; read data is held across the stall.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    mem_stage_if.slave mem_if
);

    logic        r_mem_valid;
    logic        r_hold_valid;
    logic [31:0] r_rdata_hold;
    ex_mem_t     r_payload;

    logic        w_ready_go;
    logic        w_allow_in;
    logic        w_accept;
    logic [31:0] w_word;
    logic [31:0] w_load_value;
    logic [31:0] w_final_result;
    logic        w_fwd_we;

    assign w_ready_go = 1'b1;
    assign w_allow_in = !r_mem_valid || (w_ready_go && mem_if.WB_allow_in);
    assign w_accept   = w_allow_in && mem_if.EX_to_MEM_valid;

    // Stage valid bit follows EX whenever the stage can take a new instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_valid <= 1'b0;
        end else if (w_allow_in) begin
            r_mem_valid <= mem_if.EX_to_MEM_valid;
        end
    end

    // Payload captured only on an actual accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_payload <= '0;
        end else if (w_accept) begin
            r_payload <= mem_if.EX_MEM_reg;
        end
    end

    // SRAM data is valid only in the first MEM cycle; snapshot it once on the first stalled cycle.
    // Any cycle that lets a new instruction in (or empties the stage) discards the snapshot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold_valid <= 1'b0;
            r_rdata_hold <= '0;
        end else if (w_allow_in) begin
            r_hold_valid <= 1'b0;
        end else if (r_mem_valid && !r_hold_valid && !mem_if.WB_allow_in) begin
            r_hold_valid <= 1'b1;
            r_rdata_hold <= mem_if.data_sram_rdata;
        end
    end

    assign w_word = r_hold_valid ? r_rdata_hold : mem_if.data_sram_rdata;

    mem_stage_load_align u_load_align (
        .i_word    (w_word),
        .i_off     (r_payload.alu_result[ADDR_LSB_W-1:0]),
        .i_load_op (r_payload.load_op),
        .o_value   (w_load_value)
    );

    // Result mux and output bundles.
    always_comb begin
        w_final_result = r_payload.res_from_mem ? w_load_value : r_payload.alu_result;
        w_fwd_we       = r_mem_valid && r_payload.gr_we && (r_payload.dest != 5'd0);
    end

    assign mem_if.MEM_allow_in    = w_allow_in;
    assign mem_if.MEM_to_WB_valid = r_mem_valid && w_ready_go;
    assign mem_if.MEM_WB_reg      = '{pc: r_payload.pc, gr_we: r_payload.gr_we,
                                      dest: r_payload.dest, final_result: w_final_result};
    // Fields are masked while empty so ID never sees stale dest/result.
    assign mem_if.MEM_fwd         = r_mem_valid ?
                                    '{fwd_we: w_fwd_we, dest: r_payload.dest, final_result: w_final_result} :
                                    '0;

endmodule
